// File: rtl/imu_poll_scheduler.sv
// Periodic IMU register sweeper: reads N_REGS consecutive registers each tick,
// publishes complete sweeps, and flags per-read timeouts and tick overruns.
module imu_poll_scheduler #(
  parameter int         N_REGS    = 6,
  parameter logic [7:0] BASE_ADDR = 8'h3B,
  parameter int         POLL_DIV  = 100000,
  parameter int         TIMEOUT   = 4096
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                err_clr,
  output logic                imu_start,
  output logic [7:0]          imu_reg_addr,
  input  logic [7:0]          imu_data,
  input  logic                imu_busy,
  input  logic                imu_done,
  output logic [8*N_REGS-1:0] sample_data,
  output logic                sample_valid,
  output logic [15:0]         sweep_count,
  output logic                timeout_err,
  output logic                overrun_err
);

  localparam int DW = $clog2(POLL_DIV);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(POLL_DIV - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [2:0]    IDX_LAST = 3'(N_REGS - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TICK,
    ISSUE,
    WAIT_DONE,
    PUBLISH
  } state_t;

  state_t              r_state;
  logic [DW-1:0]       r_div;
  logic [TW-1:0]       r_tcnt;
  logic [2:0]          r_idx;
  logic [7:0]          r_addr;
  logic [8*N_REGS-1:0] r_shadow;
  logic [8*N_REGS-1:0] r_sample;
  logic                r_valid;
  logic [15:0]         r_count;
  logic                r_to_err;
  logic                r_ov_err;

  logic w_tick;
  logic w_in_sweep;
  logic w_to_set;
  logic w_ov_set;

  assign w_tick     = enable && (r_div == DIV_LAST);
  assign w_in_sweep = (r_state == ISSUE) ||
                      (r_state == WAIT_DONE) ||
                      (r_state == PUBLISH);
  // done on the terminal count cycle wins over the abort
  assign w_to_set   = (r_state == WAIT_DONE) && !imu_done &&
                      (r_tcnt == TO_LAST);
  assign w_ov_set   = w_tick && w_in_sweep;

  assign imu_start    = (r_state == ISSUE) && !imu_busy;
  assign imu_reg_addr = r_addr;
  assign sample_data  = r_sample;
  assign sample_valid = r_valid;
  assign sweep_count  = r_count;
  assign timeout_err  = r_to_err;
  assign overrun_err  = r_ov_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
    end else if (!enable || w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_err <= 1'b0;
      r_ov_err <= 1'b0;
    end else begin
      if (w_to_set) begin
        r_to_err <= 1'b1;
      end else if (err_clr) begin
        r_to_err <= 1'b0;
      end
      if (w_ov_set) begin
        r_ov_err <= 1'b1;
      end else if (err_clr) begin
        r_ov_err <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_tcnt   <= '0;
      r_idx    <= '0;
      r_addr   <= BASE_ADDR;
      r_shadow <= '0;
      r_sample <= '0;
      r_valid  <= 1'b0;
      r_count  <= '0;
    end else begin
      r_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (enable) begin
            r_state <= WAIT_TICK;
          end
        end
        WAIT_TICK: begin
          if (!enable) begin
            r_state <= IDLE;
          end else if (w_tick) begin
            r_idx   <= '0;
            r_addr  <= BASE_ADDR;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          if (!imu_busy) begin
            r_tcnt  <= '0;
            r_state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (imu_done) begin
            r_shadow[8*r_idx +: 8] <= imu_data;
            if (r_idx == IDX_LAST) begin
              r_state <= PUBLISH;
            end else begin
              r_idx   <= r_idx + 3'd1;
              r_addr  <= BASE_ADDR + {5'd0, r_idx} + 8'd1;
              r_state <= ISSUE;
            end
          end else if (r_tcnt == TO_LAST) begin
            r_state <= enable ? WAIT_TICK : IDLE;
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        PUBLISH: begin
          r_sample <= r_shadow;
          r_valid  <= 1'b1;
          r_count  <= r_count + 16'd1;
          r_state  <= enable ? WAIT_TICK : IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imu_poll_scheduler.sv
// Scoreboard bench for imu_poll_scheduler with a latency-programmable
// IMU read-engine model.
module tb_imu_poll_scheduler;

  localparam int NR = 3;
  localparam int PD = 64;
  localparam int TO = 32;

  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  logic enable   = 1'b0;
  logic err_clr  = 1'b0;
  logic imu_busy = 1'b0;
  logic imu_done = 1'b0;
  logic [7:0] imu_data = 8'h00;

  logic        imu_start;
  logic [7:0]  imu_reg_addr;
  logic [23:0] sample_data;
  logic        sample_valid;
  logic [15:0] sweep_count;
  logic        timeout_err;
  logic        overrun_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_start = 0;
  int n_valid = 0;
  int last_start_cyc = 0;

  int         lat       = 5;
  logic [7:0] hang_addr = 8'h00;
  logic [7:0] doff      = 8'h00;

  logic [7:0]  q_addr[$];
  logic [23:0] q_samp[$];

  imu_poll_scheduler #(
    .N_REGS   (NR),
    .BASE_ADDR(8'h3B),
    .POLL_DIV (PD),
    .TIMEOUT  (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .err_clr     (err_clr),
    .imu_start   (imu_start),
    .imu_reg_addr(imu_reg_addr),
    .imu_data    (imu_data),
    .imu_busy    (imu_busy),
    .imu_done    (imu_done),
    .sample_data (sample_data),
    .sample_valid(sample_valid),
    .sweep_count (sweep_count),
    .timeout_err (timeout_err),
    .overrun_err (overrun_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_sweep(input logic [7:0] d);
    logic [7:0] b0, b1, b2;
    b0 = 8'hA0 + d;
    b1 = 8'hA1 + d;
    b2 = 8'hA2 + d;
    for (int i = 0; i < NR; i++) q_addr.push_back(8'h3B + 8'(i));
    q_samp.push_back({b2, b1, b0});
  endtask

  task automatic wait_valid(input string tag,
                            input int target,
                            input int budget);
    int k = 0;
    while (n_valid < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(n_valid >= target), 1);
    step(1);
  endtask

  task automatic wait_start(input string tag,
                            input int target,
                            input int budget);
    int k = 0;
    while (n_start < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(n_start >= target), 1);
    step(1);
  endtask

  task automatic rst_checks();
    chk("rst_start", imu_start, 0);
    chk("rst_addr", imu_reg_addr, 8'h3B);
    chk("rst_data", sample_data, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_count", sweep_count, 0);
    chk("rst_to", timeout_err, 0);
    chk("rst_ov", overrun_err, 0);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    step(1);
  endtask

  // scoreboard: every start and every published sample is popped here
  always @(negedge clk) begin
    logic [7:0]  ea;
    logic [23:0] es;
    if (rst_n && imu_start) begin
      n_start++;
      last_start_cyc = cyc;
      ea = 8'h00;
      if (q_addr.size() != 0) ea = q_addr.pop_front();
      chk("start_addr", imu_reg_addr, ea);
    end
    if (rst_n && sample_valid) begin
      n_valid++;
      es = 24'h0;
      if (q_samp.size() != 0) es = q_samp.pop_front();
      chk("sample", sample_data, es);
    end
  end

  // IMU engine: done pulse lat cycles after start; hang_addr never completes
  initial begin
    logic [7:0] a;
    forever begin
      if (rst_n && imu_start && imu_reg_addr != hang_addr) begin
        a = imu_reg_addr;
        repeat (lat - 1) @(negedge clk);
        imu_data = 8'hA0 + doff + (a - 8'h3B);
        imu_done = 1'b1;
        @(negedge clk);
        imu_done = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
  end

  initial begin
    int n0;
    int v0;
    int en_cyc;
    int el;
    int k;

    #12;
    rst_checks();
    step(1);
    rst_n = 1'b1;

    // basic sweep
    lat  = 5;
    doff = 8'h00;
    push_sweep(8'h00);
    step(1);
    en_cyc = cyc;
    enable = 1'b1;
    wait_start("s1_first", 1, 200);
    chk("s1_first_lat", 32'(last_start_cyc - en_cyc >= PD), 1);
    wait_valid("s1_valid", 1, 300);
    enable = 1'b0;
    step(5);
    chk("s1_nvalid", n_valid, 1);
    chk("s1_count", sweep_count, 1);
    chk("s1_data", sample_data, 24'hA2A1A0);
    chk("s1_qa", q_addr.size(), 0);

    // timeout on second register, then clean restart
    hang_addr = 8'h3C;
    q_addr.push_back(8'h3B);
    q_addr.push_back(8'h3C);
    n0 = n_start;
    enable = 1'b1;
    wait_start("s2_starts", n0 + 2, 300);
    k = 0;
    while (!timeout_err && k < 100) begin
      @(negedge clk);
      k++;
    end
    el = cyc - last_start_cyc;
    chk("s2_to_set", timeout_err, 1);
    chk("s2_to_lat", 32'(el >= TO && el <= TO + 1), 1);
    hang_addr = 8'h00;
    doff = 8'h10;
    push_sweep(8'h10);
    chk("s2_keep", sample_data, 24'hA2A1A0);
    chk("s2_nvalid", n_valid, 1);
    wait_valid("s2_valid", 2, 300);
    enable = 1'b0;
    step(5);
    chk("s2_count", sweep_count, 2);
    chk("s2_data", sample_data, 24'hB2B1B0);
    chk("s2_ov", overrun_err, 0);
    chk("s2_to_sticky", timeout_err, 1);
    pulse_clr();
    chk("s2_to_clr", timeout_err, 0);

    // slow reads overrun the tick period
    lat  = 30;
    doff = 8'h20;
    push_sweep(8'h20);
    push_sweep(8'h20);
    enable = 1'b1;
    wait_valid("s3_valid", 4, 700);
    enable = 1'b0;
    step(5);
    chk("s3_ov", overrun_err, 1);
    chk("s3_count", sweep_count, 4);
    chk("s3_data", sample_data, 24'hC2C1C0);
    pulse_clr();
    chk("s3_ov_clr", overrun_err, 0);

    // engine busy at issue time
    lat  = 5;
    doff = 8'h30;
    push_sweep(8'h30);
    imu_busy = 1'b1;
    n0 = n_start;
    enable = 1'b1;
    step(PD + 10);
    chk("s4_hold", n_start, n0);
    imu_busy = 1'b0;
    @(negedge clk);
    chk("s4_start", imu_start, 1);
    wait_valid("s4_valid", 5, 300);
    enable = 1'b0;
    step(5);
    chk("s4_nstart", n_start - n0, 3);
    chk("s4_count", sweep_count, 5);

    // enable drops during the second read
    doff = 8'h40;
    push_sweep(8'h40);
    n0 = n_start;
    enable = 1'b1;
    wait_start("s5_3c", n0 + 2, 300);
    enable = 1'b0;
    wait_valid("s5_valid", 6, 100);
    step(200);
    chk("s5_nstart", n_start - n0, 3);
    chk("s5_count", sweep_count, 6);
    chk("s5_data", sample_data, 24'hE2E1E0);

    // reset while waiting for done
    lat  = 10;
    doff = 8'h00;
    q_addr.push_back(8'h3B);
    n0 = n_start;
    v0 = n_valid;
    enable = 1'b1;
    wait_start("s6_start", n0 + 1, 300);
    step(2);
    rst_n = 1'b0;
    #1;
    rst_checks();
    enable = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(30);
    chk("s6_count", sweep_count, 0);
    chk("s6_data", sample_data, 0);
    chk("s6_nvalid", n_valid, v0);
    chk("s6_nstart", n_start, n0 + 1);
    chk("end_qa", q_addr.size(), 0);
    chk("end_qs", q_samp.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imu_poll_scheduler.md
IMU_POLL_SCHEDULER -- requirements
Module: imu_poll_scheduler

Interface
REQ-001 Parameter N_REGS, default 6: number of consecutive IMU registers read per sweep, range 1..8.
REQ-002 Parameter BASE_ADDR, default 8'h3B: register address of the first read in a sweep.
REQ-003 Parameter POLL_DIV, default 100000: clk cycles between sweep ticks, minimum 2.
REQ-004 Parameter TIMEOUT, default 4096: maximum clk cycles in WAIT_DONE per read before abort.
REQ-005 clk  in  1  single system clock; all logic on the rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 enable  in  1  level; 1 runs periodic sweeps.
REQ-008 err_clr  in  1  one-cycle pulse; clears sticky error flags.
REQ-009 imu_start  out  1  one-cycle request pulse to the IMU read engine.
REQ-010 imu_reg_addr  out  8  register address for the current read.
REQ-011 imu_data  in  8  read data from the IMU engine, valid when imu_done=1.
REQ-012 imu_busy  in  1  IMU engine transaction in progress.
REQ-013 imu_done  in  1  one-cycle pulse; read complete.
REQ-014 sample_data  out  8*N_REGS  last complete sweep; byte i at bits [8i+7:8i] holds register BASE_ADDR+i.
REQ-015 sample_valid  out  1  one-cycle pulse when sample_data updates.
REQ-016 sweep_count  out  16  number of completed sweeps.
REQ-017 timeout_err  out  1  sticky; a read exceeded TIMEOUT.
REQ-018 overrun_err  out  1  sticky; a tick arrived while a sweep was active.

Function
REQ-019 Tick divider SHALL count 0..POLL_DIV-1 while enable=1, assert tick for one cycle at POLL_DIV-1, wrap to 0, and hold at 0 while enable=0.
REQ-020 FSM states SHALL be IDLE, WAIT_TICK, ISSUE, WAIT_DONE, PUBLISH.
REQ-021 IDLE -> WAIT_TICK when enable=1; WAIT_TICK -> ISSUE on tick with index cleared to 0; WAIT_TICK -> IDLE when enable=0.
REQ-022 ISSUE SHALL drive imu_reg_addr = BASE_ADDR+index (mod 256) and, in the first cycle imu_busy=0, assert imu_start for exactly one cycle and move to WAIT_DONE; while imu_busy=1, wait in ISSUE with imu_start=0.
REQ-023 imu_reg_addr SHALL stay stable from ISSUE until imu_done or abort.
REQ-024 WAIT_DONE on imu_done SHALL store imu_data into shadow byte [index]; if index=N_REGS-1 -> PUBLISH, else index+1 -> ISSUE.
REQ-025 The WAIT_DONE cycle counter SHALL clear on entry; reaching TIMEOUT-1 without imu_done SHALL set timeout_err, discard the sweep, and go to WAIT_TICK (IDLE if enable=0).
REQ-026 imu_done in the same cycle as timeout terminal count SHALL count as completion.
REQ-027 PUBLISH SHALL copy all shadow bytes to sample_data in one cycle, pulse sample_valid, increment sweep_count (16'hFFFF wraps to 0), then go to WAIT_TICK, or IDLE if enable=0.
REQ-028 A tick in ISSUE, WAIT_DONE or PUBLISH SHALL be dropped and set overrun_err; the active sweep continues.
REQ-029 enable falling mid-sweep SHALL let the sweep complete and publish, then go to IDLE.
REQ-030 err_clr SHALL clear both sticky flags; a set in the same cycle wins.
REQ-031 imu_done outside WAIT_DONE SHALL be ignored.

Reset
REQ-032 rst_n=0 SHALL immediately force state IDLE, divider 0, index 0, imu_start 0, imu_reg_addr BASE_ADDR, sample_data 0, shadow 0, sample_valid 0, sweep_count 0, timeout_err 0, overrun_err 0.
REQ-033 After release, no imu_start SHALL occur before enable=1 and a full POLL_DIV tick period.

Verification (bench parameters N_REGS=3, BASE_ADDR=8'h3B, POLL_DIV=64, TIMEOUT=32)
REQ-034 enable=1, model returns done 5 cycles after start with data 8'hA0+i -> starts at 3B,3C,3D in order, sample_data=24'hA2A1A0, one sample_valid pulse, sweep_count=1.
REQ-035 Model never returns done for 3C -> timeout_err=1 32 cycles after that start, sample_data unchanged, no sample_valid, next tick restarts at 3B.
REQ-036 Model latency 30 cycles (sweep > 64 cycles) -> overrun_err=1, sweeps still publish, err_clr pulse -> overrun_err=0.
REQ-037 imu_busy held 1 for 10 cycles at ISSUE -> imu_start only in the cycle busy falls, exactly one pulse.
REQ-038 enable=0 during the 3C read -> 3D still read, sample_valid pulses, then no further imu_start.
REQ-039 rst_n=0 in WAIT_DONE -> all outputs at reset values in the same cycle; done pulses after release ignored, sweep_count stays 0.
